// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream feeding the program loader
interface program_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream loader into program RAM
// Frame: SYNC, START_ADDR, LEN, LEN data bytes, XOR checksum.
module program_loader #(
  parameter int         ADDR_W    = 7,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  program_loader_if.slave   stream,
  output logic [ADDR_W-1:0] inst_address,
  output logic [7:0]        inst_data,
  output logic              inst_we,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LEN,
    DATA,
    CHECK,
    ERRW
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        cnt;
  logic [7:0]        chk;
  logic [7:0]        b;
  logic              accept;

  // Never back-pressures: the pad-side receiver has no buffering.
  assign stream.in_ready = 1'b1;
  assign b               = stream.in_data;
  assign accept          = stream.in_valid;

  // rst_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state        <= IDLE;
      addr         <= '0;
      cnt          <= '0;
      chk          <= '0;
      inst_address <= '0;
      inst_data    <= '0;
      inst_we      <= 1'b0;
      core_hold    <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      inst_we   <= 1'b0;
      load_done <= 1'b0;
      if (accept) begin
        case (state)
          IDLE, ERRW: begin
            if (b == SYNC_BYTE) begin
              state     <= ADDR;
              core_hold <= 1'b1;
              load_err  <= 1'b0;
            end
          end
          ADDR: begin
            addr  <= b[ADDR_W-1:0];
            state <= LEN;
          end
          LEN: begin
            cnt   <= b;
            chk   <= '0;
            state <= (b == 8'd0) ? CHECK : DATA;
          end
          DATA: begin
            inst_address <= addr;
            inst_data    <= b;
            inst_we      <= 1'b1;
            chk          <= chk ^ b;
            addr         <= addr + 1'b1;
            cnt          <= cnt - 8'd1;
            if (cnt == 8'd1) state <= CHECK;
          end
          CHECK: begin
            if (b == chk) begin
              state     <= IDLE;
              core_hold <= 1'b0;
              load_done <= 1'b1;
            end else begin
              // Writes already issued stay in RAM; core_hold keeps the core off them.
              state    <= ERRW;
              load_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed-vector bench for program_loader
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] inst_address;
  logic [7:0] inst_data;
  logic       inst_we;
  logic       core_hold;
  logic       load_done;
  logic       load_err;

  int vectors     = 0;
  int miscompares = 0;

  program_loader_if stream_if ();

  program_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stream       (stream_if),
    .inst_address (inst_address),
    .inst_data    (inst_data),
    .inst_we      (inst_we),
    .core_hold    (core_hold),
    .load_done    (load_done),
    .load_err     (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Status vector is {inst_we, load_done, core_hold, load_err}.
  task automatic check_st(input string tag, input logic [3:0] exp);
    check(tag, 8'({inst_we, load_done, core_hold, load_err}), 8'(exp));
  endtask

  task automatic put(input logic [7:0] b);
    stream_if.in_data  = b;
    stream_if.in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    stream_if.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic put_w(input string tag, input logic [7:0] b, input logic [7:0] a);
    put(b);
    check({tag, " we"},   8'(inst_we), 8'h01);
    check({tag, " addr"}, 8'(inst_address), a);
    check({tag, " data"}, inst_data, b);
  endtask

  initial begin
    rst_n              = 1'b1;
    stream_if.in_valid = 1'b0;
    stream_if.in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_st("reset status", 4'b0000);
    check("reset addr", 8'(inst_address), 8'h00);
    check("reset data", inst_data, 8'h00);
    check("in_ready", 8'(stream_if.in_ready), 8'h01);
    rst_n = 1'b0;

    // 1: basic back-to-back load
    put(8'hA5);
    check_st("t1 sync", 4'b0010);
    put(8'h10);
    put(8'h03);
    check_st("t1 len", 4'b0010);
    put_w("t1 w0", 8'h11, 8'h10);
    put_w("t1 w1", 8'h22, 8'h11);
    put_w("t1 w2", 8'h44, 8'h12);
    put(8'h77);
    check_st("t1 chk", 4'b0100);
    gap();
    check_st("t1 after", 4'b0000);
    check("t1 hold addr", 8'(inst_address), 8'h12);
    check("t1 hold data", inst_data, 8'h44);

    // 2: address wrap 7F -> 00
    put(8'hA5); put(8'h7E); put(8'h03);
    put_w("t2 w0", 8'h01, 8'h7E);
    put_w("t2 w1", 8'h02, 8'h7F);
    put_w("t2 w2", 8'h04, 8'h00);
    put(8'h07);
    check_st("t2 chk", 4'b0100);

    // 3: bad checksum, then recovery
    put(8'hA5); put(8'h00); put(8'h02);
    put_w("t3 w0", 8'hAA, 8'h00);
    put_w("t3 w1", 8'h55, 8'h01);
    put(8'h00);
    check_st("t3 bad", 4'b0011);
    gap();
    put(8'h3C);
    check_st("t3 errw junk", 4'b0011);
    put(8'hA5);
    check_st("t3 resync", 4'b0010);
    put(8'h30); put(8'h01);
    put_w("t3 w2", 8'h5C, 8'h30);
    put(8'h5C);
    check_st("t3 good", 4'b0100);

    // 4: zero-length frames
    put(8'hA5); put(8'h20); put(8'h00);
    check_st("t4 len0", 4'b0010);
    put(8'h00);
    check_st("t4 ok", 4'b0100);
    put(8'hA5); put(8'h20); put(8'h00); put(8'h01);
    check_st("t4 bad", 4'b0011);
    put(8'hA5); put(8'h20); put(8'h00); put(8'h00);
    check_st("t4 recover", 4'b0100);

    // 5: idle garbage with gaps, then sync byte as payload
    put(8'h00); gap();
    put(8'hFF); gap(); gap();
    put(8'h5A);
    check_st("t5 idle", 4'b0000);
    put(8'hA5); put(8'h05); put(8'h02);
    put_w("t5 w0", 8'hA5, 8'h05);
    put_w("t5 w1", 8'hA5, 8'h06);
    put(8'h00);
    check_st("t5 chk", 4'b0100);

    // 6: reset mid-frame
    put(8'hA5); put(8'h40); put(8'h03);
    put_w("t6 w0", 8'h11, 8'h40);
    stream_if.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    check_st("t6 reset", 4'b0000);
    put(8'h22);
    check_st("t6 ignored", 4'b0000);
    put(8'h44);
    check_st("t6 ignored2", 4'b0000);
    put(8'hA5); put(8'h50); put(8'h01);
    put_w("t6 w1", 8'h99, 8'h50);
    put(8'h99);
    check_st("t6 good", 4'b0100);
    gap();
    check_st("t6 end", 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
